// File: rtl/ir_emu_pkg.sv
// Shared types and constants for the reflective IR sensor emulator.
// Channel state encoding, crossing counter width and noise LFSR setup.
package ir_emu_pkg;

    typedef enum logic [1:0] {
        OFF,
        RISE,
        ON,
        FALL
    } ir_chan_state_t;

    localparam logic [3:0]  GAP_MAX   = 4'hF;
    localparam int          CROSS_W   = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ir_chan_resp.sv
// One phototransistor channel: rise/fall delay FSM with a registered
// active-low output.
module ir_chan_resp
    import ir_emu_pkg::*;
#(
    parameter int RISE_DLY = 64,
    parameter int FALL_DLY = 32,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic stim,
    output logic IR_n,
    output logic is_off
);

    localparam logic [CNT_W-1:0] RISE_END = CNT_W'(RISE_DLY - 1);
    localparam logic [CNT_W-1:0] FALL_END = CNT_W'(FALL_DLY - 1);

    ir_chan_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ir_n_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (stim) begin
                    state_d = RISE;
                    cnt_d   = '0;
                end
            end
            RISE: begin
                if (!stim)                 state_d = OFF;
                else if (cnt_q == RISE_END) state_d = ON;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            ON: begin
                if (!stim) begin
                    state_d = FALL;
                    cnt_d   = '0;
                end
            end
            FALL: begin
                // Re-illumination cancels the fall outright
                if (stim)                  state_d = ON;
                else if (cnt_q == FALL_END) state_d = OFF;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            ir_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_n_q  <= !(state_d == ON || state_d == FALL);
        end
    end

    assign IR_n   = ir_n_q;
    assign is_off = (state_q == OFF);

endmodule

// File: rtl/ir_sensor_emu.sv
// Emulator of the three reflective IR sensors: envelope detector, crossing
// scheduler, three channel responders. IR_EMU_NOISE_EN adds LFSR glitches.
module ir_sensor_emu
    import ir_emu_pkg::*;
#(
    parameter int ENV_HOLD = 8,
    parameter int RISE_DLY = 64,
    parameter int FALL_DLY = 32,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IR_en,
    input  logic               lft_line,
    input  logic               rght_line,
    input  logic               cross_req,
    input  logic [CROSS_W-1:0] cross_len,
    output logic               cross_busy,
    output logic               cross_done,
    output logic               lftIR_n,
    output logic               cntrIR_n,
    output logic               rghtIR_n,
    output logic               emit_act
);

    logic [3:0]         gap_q, gap_d;
    logic [CROSS_W-1:0] xcnt_q, xcnt_d;
    logic               done_q, done_d;
    logic               accept;
    logic [2:0]         stim, raw_n, chan_off, frc;

    assign emit_act   = (gap_q < 4'(ENV_HOLD));
    assign cross_busy = (xcnt_q != '0);
    assign cross_done = done_q;
    assign accept     = cross_req & ~cross_busy & (cross_len != '0);

    always_comb begin
        gap_d = gap_q;
        if (IR_en)                gap_d = '0;
        else if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;

        xcnt_d = xcnt_q;
        if (cross_busy)  xcnt_d = xcnt_q - 1'b1;
        else if (accept) xcnt_d = cross_len;

        done_d = (xcnt_q == CROSS_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q  <= GAP_MAX;
            xcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            gap_q  <= gap_d;
            xcnt_q <= xcnt_d;
            done_q <= done_d;
        end
    end

    // Bit 0 left, bit 1 center, bit 2 right
    assign stim = {3{emit_act}} & {rght_line, cross_busy, lft_line};

    ir_chan_resp #(
        .RISE_DLY(RISE_DLY), .FALL_DLY(FALL_DLY), .CNT_W(CNT_W)
    ) u_lft (
        .clk(clk), .rst(rst), .stim(stim[0]),
        .IR_n(raw_n[0]), .is_off(chan_off[0])
    );

    ir_chan_resp #(
        .RISE_DLY(RISE_DLY), .FALL_DLY(FALL_DLY), .CNT_W(CNT_W)
    ) u_cntr (
        .clk(clk), .rst(rst), .stim(stim[1]),
        .IR_n(raw_n[1]), .is_off(chan_off[1])
    );

    ir_chan_resp #(
        .RISE_DLY(RISE_DLY), .FALL_DLY(FALL_DLY), .CNT_W(CNT_W)
    ) u_rght (
        .clk(clk), .rst(rst), .stim(stim[2]),
        .IR_n(raw_n[2]), .is_off(chan_off[2])
    );

`ifdef IR_EMU_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  rr_q, rr_d;
    logic        hit;

    assign hit = (lfsr_q[5:0] == 6'd0);

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
        rr_d   = rr_q;
        if (hit) rr_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 1'b1;
        frc = '0;
        if (hit) frc[rr_q] = chan_off[rr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            rr_q   <= 2'd0;
        end else begin
            lfsr_q <= lfsr_d;
            rr_q   <= rr_d;
        end
    end
`else
    assign frc = '0;
`endif

    assign lftIR_n  = raw_n[0] & ~frc[0];
    assign cntrIR_n = raw_n[1] & ~frc[1];
    assign rghtIR_n = raw_n[2] & ~frc[2];

endmodule
